// File: rtl/priority_arbiter_rr_if.sv
// Request/grant bundle for priority_arbiter_rr.
// The master side (request sources and grant consumer) drives req, rr_en and
// out_ready; the slave side (the arbiter) returns the registered grant and
// the combinational any flag.
interface priority_arbiter_rr_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic         rr_en;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] num;
  logic [N-1:0] onehot;
  logic         any;

  modport master (
    output req, rr_en, out_ready,
    input  out_valid, num, onehot, any
  );

  modport slave (
    input  req, rr_en, out_ready,
    output out_valid, num, onehot, any
  );
endinterface

// File: rtl/priority_arbiter_rr.sv
// Registered N-input arbiter with selectable fixed (highest index wins) or
// round-robin priority. A grant is presented as a binary index plus a one-hot
// vector and is held stable until the consumer accepts it with out_ready.
// On accept the arbiter re-arbitrates in the same cycle, so with out_ready
// held high and requests pending it issues one grant per cycle.
// N must match the N of the connected interface instance (legal 2..64).
module priority_arbiter_rr #(
  parameter int N = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  priority_arbiter_rr_if.slave    bus
);
  localparam int W = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t       state, state_n;
  logic [W-1:0] ptr, ptr_n;
  logic         valid_q, valid_n;
  logic [W-1:0] num_q, num_n;
  logic [N-1:0] onehot_q, onehot_n;
  logic [W-1:0] arb_ptr;
  logic [W-1:0] arb_num;
  logic         load;

  // Winner selection. In round-robin mode the scan starts at p and wraps at
  // N-1 (not 2^W-1), so indices >= N are never produced for non-power-of-two N.
  function automatic logic [W-1:0] arbitrate(input logic [N-1:0] r,
                                              input logic [W-1:0] p,
                                              input logic         rr);
    logic [W-1:0] win;
    logic         found;
    int           idx;
    win   = '0;
    found = 1'b0;
    if (!rr) begin
      for (int i = 0; i < N; i++) begin
        if (r[i]) win = W'(i);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = int'(p) + k;
        if (idx >= N) idx = idx - N;
        if (!found && r[idx]) begin
          win   = W'(idx);
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

  assign bus.any       = |bus.req;
  assign bus.out_valid = valid_q;
  assign bus.num       = num_q;
  assign bus.onehot    = onehot_q;

  // Next-state logic: load a new grant from IDLE or on an accept, otherwise
  // freeze the held grant; the pointer only advances on a round-robin accept.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    valid_n  = valid_q;
    num_n    = num_q;
    onehot_n = onehot_q;
    arb_ptr  = ptr;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) load = 1'b1;
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (bus.rr_en) ptr_n = (num_q == W'(N - 1)) ? '0 : num_q + W'(1);
          arb_ptr = ptr_n;
          if (|bus.req) begin
            load = 1'b1;
          end else begin
            state_n  = IDLE;
            valid_n  = 1'b0;
            num_n    = '0;
            onehot_n = '0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    arb_num = arbitrate(bus.req, arb_ptr, bus.rr_en);
    if (load) begin
      state_n  = HOLD;
      valid_n  = 1'b1;
      num_n    = arb_num;
      onehot_n = {{(N-1){1'b0}}, 1'b1} << arb_num;
    end
  end

  // State and grant registers; reset drops any held grant and rewinds the pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      valid_q  <= 1'b0;
      num_q    <= '0;
      onehot_q <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      valid_q  <= valid_n;
      num_q    <= num_n;
      onehot_q <= onehot_n;
    end
  end
endmodule

// File: doc/priority_arbiter_rr.md
# priority_arbiter_rr

Parametrised, registered successor to the 8-input combinational priority encoder. Takes N request lines and selects one per arbitration using either fixed highest-index-wins priority or round-robin. It presents the winner as a binary index plus a one-hot vector behind a valid/ready handshake. It sits between request sources (DMA/line-fetch clients of the video pipeline) and a single shared resource, and holds each grant stable until the consumer accepts it.

## Interface
- N, 8, number of request lines; legal range 2..64, non-power-of-two allowed
- W, $clog2(N), index width (localparam, derived, not overridable)
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- req  in  N  request vector; bit i = requester i
- rr_en  in  1  0 = fixed priority (highest index wins), 1 = round-robin
- out_ready  in  1  consumer accepts current grant when out_valid && out_ready
- out_valid  out  1  registered; grant present
- num  out  W  registered; index of granted requester
- onehot  out  N  registered; one-hot of num, all-zero when out_valid=0
- any  out  1  combinational |req (same semantics as encoder's any)

## Operation
- State: IDLE (out_valid=0), HOLD (out_valid=1). Plus rr pointer ptr[W-1:0].
- Arbitration function arb(req, ptr, rr_en):
  - rr_en=0: highest set index of req.
  - rr_en=1: first set index scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap at N-1 to 0, not at 2^W-1).
- IDLE: if req != 0 -> load num=arb(...), onehot=1<<num, go HOLD. Else stay.
- HOLD, out_ready=0: num/onehot/out_valid frozen; req changes ignored (no retraction, no pre-emption even if higher-priority request appears or granted req drops).
- HOLD, out_ready=1 (accept):
  - if rr_en=1 (value sampled this cycle): ptr <= (num==N-1) ? 0 : num+1; else ptr unchanged.
  - re-arbitrate same cycle with ptr_next: if req != 0 load new winner and stay HOLD (back-to-back); else go IDLE, out_valid<=0, num<=0, onehot<=0.
- rr_en change takes effect at next arbitration; never alters a held grant.
- Index values ≥ N never produced.

## Timing
- Reset (synchronous, takes priority over all): out_valid=0, num=0, onehot=0, ptr=0, state IDLE. Applies mid-HOLD: grant dropped at that edge, no accept recorded, ptr not advanced.
- any: no reset value, purely combinational from req.
- Latency: req asserted in cycle t (state IDLE) -> out_valid=1 with num valid in cycle t+1.
- Throughput: 1 grant per cycle with out_ready held high and req non-zero.
- Req sampled only on arbitration edges (IDLE with req!=0, or accept edge); pulses between are lost by design.
- Simultaneous accept and reset: reset wins.

## Test plan
- Reset with req=0 -> out_valid=0, num=0, onehot=0, any=0; release reset, req=0 for 3 cycles -> outputs unchanged.
- N=8, rr_en=0, req=8'b00010010, out_ready=1 -> any=1 same cycle; next cycle out_valid=1, num=4, onehot=8'b00010000; repeats num=4 each cycle while req held.
- N=8, rr_en=0, req=8'hFF, out_ready=0 for 3 cycles, req changed to 8'h01 in cycle 2 -> num=7 held all 3 cycles; raise out_ready -> next grant num=0; then req=0 -> out_valid=0, onehot=0.
- N=8, rr_en=1, req=8'hFF, out_ready=1 -> num sequence 0,1,2,...,7,0,1 one per cycle.
- N=5, rr_en=1, req=5'b10001, out_ready=1 -> num 0,4,0,4 (wrap at 4->0, no index 5..7).
- N=8, rr_en=1, grant num=3 held, assert reset with out_ready=1 -> next cycle out_valid=0, num=0, ptr=0; release reset with req=8'b00001000 -> num=3 (scan from 0).
